conv_window_fetch: RTL

- Parametrised image-window fetch engine; generalises the fixed 4x4-block, 4-bank image reader.
- Reads a row-major single-channel image from a synchronous image RAM (1-cycle read latency) and assembles each KxK convolution window into a flat vector.
- Presents each window to the CNN datapath over a valid/ready handshake; supports runtime stride (1 or 2) and repeating the full sweep once per filter pass.
- Sits between the image RAMs and the conv/SSFR datapath; started by the control-register decoder.

---
 rtl/conv_pkg.sv | 13 +
 rtl/win_addr_gen.sv | 28 ++
 rtl/conv_window_fetch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window fetch engine.
package conv_pkg;

  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {IDLE, FETCH, LAST, PRESENT} fetch_state_t;

  // Number of whole windows along one image axis for a given stride.
  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

endpackage

// File: rtl/win_addr_gen.sv
// Image RAM address for tap (i,j) of the window at output position (r,c).
module win_addr_gen #(
  parameter int IMG_W  = 28,
  parameter int ADDR_W = 14,
  parameter int TW     = 2
) (
  input  logic [7:0]        row_i,
  input  logic [7:0]        col_i,
  input  logic [TW-1:0]     tapI_i,
  input  logic [TW-1:0]     tapJ_i,
  input  logic              stride2_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int AW = ADDR_W + 8;

  logic [AW-1:0] rowPix;
  logic [AW-1:0] colPix;

  // Wide intermediate keeps the sum exact; wrap-around happens only at the final truncation.
  always_comb begin
    rowPix = (AW'(row_i) << stride2_i) + AW'(tapI_i);
    colPix = (AW'(col_i) << stride2_i) + AW'(tapJ_i);
    addr_o = ADDR_W'(AW'(base_i) + rowPix * AW'(IMG_W) + colPix);
  end

endmodule

// File: rtl/conv_window_fetch.sv
// Fetches KxK image windows from a 1-cycle-latency RAM and hands them out over valid/ready.
module conv_window_fetch
  import conv_pkg::*;
#(
  parameter int DW     = DW_DEFAULT,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 14,
  parameter int PASS_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic                stride2_i,
  input  logic [PASS_W-1:0]   num_passes_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic                ram_rden_o,
  input  logic [DW-1:0]       ram_q_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [K*K*DW-1:0]   out_window_o,
  output logic [7:0]          out_row_o,
  output logic [7:0]          out_col_o,
  output logic [PASS_W-1:0]   out_pass_o,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int NT     = K * K;
  localparam int TW     = (K > 1) ? $clog2(K) : 1;
  localparam int OUT_W1 = out_dim(IMG_W, K, 1);
  localparam int OUT_W2 = out_dim(IMG_W, K, 2);
  localparam int OUT_H1 = out_dim(IMG_H, K, 1);
  localparam int OUT_H2 = out_dim(IMG_H, K, 2);

  if (OUT_W1 > 256 || OUT_H1 > 256 || OUT_W1 < 1 || OUT_H1 < 1) begin : g_dimCheck
    $error("conv_window_fetch: output dimensions must lie in 1..256");
  end

  fetch_state_t        state_q, state_d;
  logic                stride_q, stride_d;
  logic [PASS_W-1:0]   numPasses_q, numPasses_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [7:0]          row_q, row_d, col_q, col_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [TW-1:0]       tapI_q, tapI_d, tapJ_q, tapJ_d;
  logic                done_q, done_d;
  logic                capValid_q;
  logic [NT*DW-1:0]    window_q;
  logic [(NT+1)*DW-1:0] windowShift;
  logic [7:0]          colMax, rowMax;
  logic                lastCol, lastRow, lastPass, lastTap;
  logic [ADDR_W-1:0]   genAddr;

  win_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W), .TW(TW)) u_addrGen (
    .row_i     (row_q),
    .col_i     (col_q),
    .tapI_i    (tapI_q),
    .tapJ_i    (tapJ_q),
    .stride2_i (stride_q),
    .base_i    (base_q),
    .addr_o    (genAddr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stride_q    <= 1'b0;
      numPasses_q <= '0;
      base_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pass_q      <= '0;
      tapI_q      <= '0;
      tapJ_q      <= '0;
      done_q      <= 1'b0;
      capValid_q  <= 1'b0;
      window_q    <= '0;
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      numPasses_q <= numPasses_d;
      base_q      <= base_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pass_q      <= pass_d;
      tapI_q      <= tapI_d;
      tapJ_q      <= tapJ_d;
      done_q      <= done_d;
      capValid_q  <= (state_q == FETCH);
      if (capValid_q) window_q <= windowShift[(NT+1)*DW-1:DW];
    end
  end

  // Taps arrive in row-major order, so shifting in from the top leaves tap 0 at the LSBs.
  assign windowShift = {ram_q_i, window_q};

  assign colMax   = stride_q ? 8'(OUT_W2 - 1) : 8'(OUT_W1 - 1);
  assign rowMax   = stride_q ? 8'(OUT_H2 - 1) : 8'(OUT_H1 - 1);
  assign lastCol  = (col_q == colMax);
  assign lastRow  = (row_q == rowMax);
  assign lastPass = (pass_q == numPasses_q - PASS_W'(1));
  assign lastTap  = (tapI_q == TW'(K - 1)) && (tapJ_q == TW'(K - 1));

  always_comb begin
    state_d     = state_q;
    stride_d    = stride_q;
    numPasses_d = numPasses_q;
    base_d      = base_q;
    row_d       = row_q;
    col_d       = col_q;
    pass_d      = pass_q;
    tapI_d      = tapI_q;
    tapJ_d      = tapJ_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          stride_d    = stride2_i;
          numPasses_d = num_passes_i;
          base_d      = base_addr_i;
          row_d       = '0;
          col_d       = '0;
          pass_d      = '0;
          tapI_d      = '0;
          tapJ_d      = '0;
          if (num_passes_i == '0) done_d = 1'b1;
          else                    state_d = FETCH;
        end
      end
      FETCH: begin
        if (lastTap) begin
          tapI_d  = '0;
          tapJ_d  = '0;
          state_d = LAST;
        end else if (tapJ_q == TW'(K - 1)) begin
          tapJ_d = '0;
          tapI_d = tapI_q + TW'(1);
        end else begin
          tapJ_d = tapJ_q + TW'(1);
        end
      end
      LAST: state_d = PRESENT;
      PRESENT: begin
        if (out_ready_i) begin
          state_d = FETCH;
          if (!lastCol) begin
            col_d = col_q + 8'd1;
          end else begin
            col_d = '0;
            if (!lastRow) begin
              row_d = row_q + 8'd1;
            end else begin
              row_d = '0;
              if (!lastPass) begin
                pass_d = pass_q + PASS_W'(1);
              end else begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_rden_o   = (state_q == FETCH);
  assign ram_addr_o   = (state_q == FETCH) ? genAddr : '0;
  assign out_valid_o  = (state_q == PRESENT);
  assign out_window_o = window_q;
  assign out_row_o    = row_q;
  assign out_col_o    = col_q;
  assign out_pass_o   = pass_q;
  assign out_last_o   = (state_q == PRESENT) && lastCol && lastRow && lastPass;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

endmodule
